// File: rtl/yuv444_to_422_filt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : yuv_pkg
// Description : Shared constants and helpers for the 4:4:4 -> 4:2:2 chroma
//               down-converter.
// Revision    : 1.0 - initial release
// ============================================================================
package yuv_pkg;

    localparam int MODE_DROP = 0;
    localparam int MODE_AVG2 = 1;
    localparam int MODE_TAP3 = 2;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    // 8-bit video level scaled up to a DW-bit component (DW in 8..12).
    function automatic logic [11:0] blank_level(input int base, input int dw);
        return 12'(base << (dw - 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/yuv444_to_422_filt_chroma_tap3.sv
`default_nettype none
// ============================================================================
// Module      : chroma_tap3
// Description : Combinational chroma filter: drop, 2-tap average or [1 2 1]/4.
// Revision    : 1.0 - initial release
// ============================================================================
module chroma_tap3
    import yuv_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]    i_mode,
    input  logic [DW-1:0] i_prev,
    input  logic [DW-1:0] i_centre,
    input  logic [DW-1:0] i_next,
    output logic [DW-1:0] o_res
);

    logic [DW:0]   w_sum2;
    logic [DW+1:0] w_sum3;

    // Sums carry enough headroom that the rounded quotient always fits DW bits.
    assign w_sum2 = {1'b0, i_centre} + {1'b0, i_next} + (DW+1)'(1);
    assign w_sum3 = {2'b00, i_prev} + {1'b0, i_centre, 1'b0} + {2'b00, i_next} + (DW+2)'(2);

    always_comb begin
        o_res = i_centre;
        case (i_mode)
            2'(MODE_AVG2): o_res = DW'(w_sum2 >> 1);
            2'(MODE_TAP3): o_res = DW'(w_sum3 >> 2);
            default:       o_res = i_centre;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/yuv444_to_422_filt.sv
`default_nettype none
// ============================================================================
// Module      : yuv444_to_422_filt
// Description : YUV 4:4:4 to 4:2:2 chroma down-converter, fixed 3-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module yuv444_to_422_filt
    import yuv_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MODE     = 1,
    parameter bit CB_FIRST = 1'b1
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          i_vs,
    input  logic          i_hs,
    input  logic          i_de,
    input  logic [DW-1:0] i_y,
    input  logic [DW-1:0] i_cb,
    input  logic [DW-1:0] i_cr,
    output logic          o_vs,
    output logic          o_hs,
    output logic          o_de,
    output logic [DW-1:0] o_y,
    output logic [DW-1:0] o_c
);

    localparam logic [DW-1:0] c_blank_y = DW'(blank_level(16, DW));
    localparam logic [DW-1:0] c_blank_c = DW'(blank_level(128, DW));

    logic          r_p1_de, r_p1_hs, r_p1_vs;
    logic [DW-1:0] r_p1_y, r_p1_cb, r_p1_cr;
    logic          r_p2_de, r_p2_hs, r_p2_vs;
    logic [DW-1:0] r_p2_y, r_p2_cb, r_p2_cr;
    logic          r_p3_de;
    logic [DW-1:0] r_p3_cb, r_p3_cr;

    phase_e        r_phase;
    logic [DW-1:0] r_c_hold;

    logic          r_o_vs, r_o_hs, r_o_de;
    logic [DW-1:0] r_o_y, r_o_c;

    logic [DW-1:0] w_prev_cb, w_next_cb, w_prev_cr, w_next_cr;
    logic [DW-1:0] w_cb_f, w_cr_f, w_even_c, w_odd_c;
    logic          w_line_start;
    phase_e        w_phase;

    // Missing neighbours at a line edge are replaced by the centre pixel.
    assign w_prev_cb = r_p3_de ? r_p3_cb : r_p2_cb;
    assign w_next_cb = r_p1_de ? r_p1_cb : r_p2_cb;
    assign w_prev_cr = r_p3_de ? r_p3_cr : r_p2_cr;
    assign w_next_cr = r_p1_de ? r_p1_cr : r_p2_cr;

    chroma_tap3 #(.DW(DW)) u_tap_cb (
        .i_mode   (2'(MODE)),
        .i_prev   (w_prev_cb),
        .i_centre (r_p2_cb),
        .i_next   (w_next_cb),
        .o_res    (w_cb_f)
    );

    chroma_tap3 #(.DW(DW)) u_tap_cr (
        .i_mode   (2'(MODE)),
        .i_prev   (w_prev_cr),
        .i_centre (r_p2_cr),
        .i_next   (w_next_cr),
        .o_res    (w_cr_f)
    );

    assign w_line_start = r_p2_de & ~r_p3_de;
    assign w_phase      = w_line_start ? PH_EVEN : r_phase;
    assign w_even_c     = CB_FIRST ? w_cb_f : w_cr_f;
    assign w_odd_c      = CB_FIRST ? w_cr_f : w_cb_f;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_de  <= 1'b0;
            r_p1_hs  <= 1'b0;
            r_p1_vs  <= 1'b0;
            r_p1_y   <= '0;
            r_p1_cb  <= '0;
            r_p1_cr  <= '0;
            r_p2_de  <= 1'b0;
            r_p2_hs  <= 1'b0;
            r_p2_vs  <= 1'b0;
            r_p2_y   <= '0;
            r_p2_cb  <= '0;
            r_p2_cr  <= '0;
            r_p3_de  <= 1'b0;
            r_p3_cb  <= '0;
            r_p3_cr  <= '0;
            r_phase  <= PH_EVEN;
            r_c_hold <= '0;
            r_o_vs   <= 1'b0;
            r_o_hs   <= 1'b0;
            r_o_de   <= 1'b0;
            r_o_y    <= c_blank_y;
            r_o_c    <= c_blank_c;
        end else begin
            r_p1_de <= i_de;
            r_p1_hs <= i_hs;
            r_p1_vs <= i_vs;
            r_p1_y  <= i_y;
            r_p1_cb <= i_cb;
            r_p1_cr <= i_cr;
            r_p2_de <= r_p1_de;
            r_p2_hs <= r_p1_hs;
            r_p2_vs <= r_p1_vs;
            r_p2_y  <= r_p1_y;
            r_p2_cb <= r_p1_cb;
            r_p2_cr <= r_p1_cr;
            r_p3_de <= r_p2_de;
            r_p3_cb <= r_p2_cb;
            r_p3_cr <= r_p2_cr;

            r_o_de <= r_p2_de;
            r_o_hs <= r_p2_hs;
            r_o_vs <= r_p2_vs;

            if (r_p2_de) begin
                r_phase <= (w_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
                r_o_y   <= r_p2_y;
                if (w_phase == PH_EVEN) begin
                    r_o_c    <= w_even_c;
                    r_c_hold <= w_odd_c;
                end else begin
                    r_o_c <= r_c_hold;
                end
            end else begin
                r_o_y <= c_blank_y;
                r_o_c <= c_blank_c;
            end
        end
    end

    assign o_vs = r_o_vs;
    assign o_hs = r_o_hs;
    assign o_de = r_o_de;
    assign o_y  = r_o_y;
    assign o_c  = r_o_c;

endmodule
`default_nettype wire
